// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte type, S-box table and state byte accessor
package aes_pkg;
   typedef logic [7:0] byte_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} sbi_state_t;
   localparam logic [2047:0] SBOX = {
      128'h637c777b_f26b6fc5_3001672b_fed7ab76,
      128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
      128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
      128'h04c723c3_1896059a_071280e2_eb27b275,
      128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
      128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
      128'hd0efaafb_434d3385_45f9027f_503c9fa8,
      128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
      128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
      128'h60814fdc_222a9088_46eeb814_de5e0bdb,
      128'he0323a0a_4906245c_c2d3ac62_9195e479,
      128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
      128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
      128'h703eb566_4803f60e_613557b9_86c11d9e,
      128'he1f89811_69d98e94_9b1e87e9_ce5528df,
      128'h8ca1890d_bfe64268_41992d0f_b054bb16
   };
   function automatic byte_t sbox(input byte_t b);
      return SBOX[2047 - 8 * int'(b) -: 8];
   endfunction
   function automatic byte_t state_byte(input logic [127:0] s, input int i);
      return s[127 - 8 * i -: 8];
   endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box lookup
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o
);
   assign byte_o = sbox(byte_i);
endmodule

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes, LANES bytes per cycle through shared S-boxes
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out
);
   localparam int N  = 16 / LANES;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   sbi_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [127:0] work_q, work_d, out_q, out_d, sub;
   logic out_valid_q, out_valid_d;
   byte_t sb_in [LANES];
   byte_t sb_out [LANES];
   logic last;
   for (genvar g = 0; g < LANES; g++) begin : g_sbox
      aes_sbox u_sbox (.byte_i(sb_in[g]), .byte_o(sb_out[g]));
   end
   assign last      = cnt_q == CW'(N - 1);
   assign in_ready  = state_q == IDLE;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   // route the current byte group through the S-boxes and splice the results back
   always_comb begin
      sub = work_q;
      for (int l = 0; l < LANES; l++) begin
         sb_in[l] = state_byte(work_q, int'(cnt_q) * LANES + l);
         sub[127 - 8 * (int'(cnt_q) * LANES + l) -: 8] = sb_out[l];
      end
   end
   // next state: accept in IDLE, one group per BUSY cycle, hold result in DONE until taken
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            work_d  = in;
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            work_d = sub;
            cnt_d  = cnt_q + CW'(1);
            if (last) begin
               out_d       = sub;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers; reset drops any in-flight state and clears the output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: directed and random checks of sub_bytes_iter for LANES 1, 4 and 16
module tb_sub_bytes_iter;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [127:0] din = '0;
   logic rdy1, rdy4, rdy16, ov1, ov4, ov16;
   logic [127:0] o1, o4, o16;
   int checks = 0, errors = 0;
   logic [7:0] ref_sb [256];
   logic [127:0] exp_q [$];
   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;
   vec_t vecs [4];

   always #5 clk = ~clk;

   sub_bytes_iter #(.LANES(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in(din),
      .out_valid(ov1), .out_ready(out_ready), .out(o1));
   sub_bytes_iter #(.LANES(4)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in(din),
      .out_valid(ov4), .out_ready(out_ready), .out(o4));
   sub_bytes_iter #(.LANES(16)) u16 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in(din),
      .out_valid(ov16), .out_ready(out_ready), .out(o16));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] w = {b, b} << n;
      return w[15:8];
   endfunction

   function automatic logic [127:0] sub_model(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = ref_sb[s[127 - 8 * i -: 8]];
      return r;
   endfunction

   task automatic wait_out(output int lat);
      lat = 0;
      while (!ov4 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, l1, l4, l16;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         ref_sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      vecs[0] = '{128'h00102030405060708090a0b0c0d0e0f0, 128'h63cab7040953d051cd60e0e7ba70e18c};
      vecs[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
      vecs[2] = '{{16{8'h00}}, {16{8'h63}}};
      vecs[3] = '{{16{8'hff}}, {16{8'h16}}};

      repeat (2) @(negedge clk);
      chkb("rst_in_ready", rdy4, 1'b1);
      chkb("rst_out_valid", ov4, 1'b0);
      chk("rst_out", o4, '0);
      chk("rst_out_l1", o1, '0);
      chk("rst_out_l16", o16, '0);
      rst = 1'b0;
      @(negedge clk);

      out_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         din = vecs[v].din;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         din = ~din;
         chkb($sformatf("busy_ready%0d", v), rdy4, 1'b0);
         wait_out(lat);
         chk($sformatf("lat%0d", v), 128'(lat), 128'd4);
         chk($sformatf("out%0d", v), o4, vecs[v].dout);
         @(negedge clk);
         chkb($sformatf("hs_valid%0d", v), ov4, 1'b0);
         chkb($sformatf("hs_ready%0d", v), rdy4, 1'b1);
      end

      out_ready = 1'b0;
      din = vecs[0].din;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      din = vecs[2].din;
      wait_out(lat);
      chk("bp_lat", 128'(lat), 128'd4);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("bp_out%0d", c), o4, vecs[0].dout);
         chkb($sformatf("bp_valid%0d", c), ov4, 1'b1);
         chkb($sformatf("bp_ready%0d", c), rdy4, 1'b0);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chkb("bp_rel_valid", ov4, 1'b0);
      chkb("bp_rel_ready", rdy4, 1'b1);
      chk("bp_rel_out", o4, vecs[0].dout);
      @(negedge clk);
      chkb("bp_no_dup", ov4, 1'b0);

      din = vecs[1].din;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chkb("midrst_valid", ov4, 1'b0);
      chk("midrst_out", o4, '0);
      chkb("midrst_ready", rdy4, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      din = vecs[2].din;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat);
      chk("postrst_lat", 128'(lat), 128'd4);
      chk("postrst_out", o4, vecs[2].dout);
      @(negedge clk);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
      din = vecs[1].din;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      l1 = -1;
      l4 = -1;
      l16 = -1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (ov1 && l1 < 0) l1 = k;
         if (ov4 && l4 < 0) l4 = k;
         if (ov16 && l16 < 0) l16 = k;
      end
      chk("lanes1_lat", 128'(l1), 128'd16);
      chk("lanes4_lat", 128'(l4), 128'd4);
      chk("lanes16_lat", 128'(l16), 128'd1);
      chk("lanes1_out", o1, vecs[1].dout);
      chk("lanes4_out", o4, vecs[1].dout);
      chk("lanes16_out", o16, vecs[1].dout);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);

      fork
         begin
            for (int i = 0; i < 20; i++) begin
               int g = 0;
               din = {$urandom, $urandom, $urandom, $urandom};
               in_valid = 1'b1;
               while (!rdy4 && g < 500) begin
                  @(negedge clk);
                  g++;
               end
               exp_q.push_back(sub_model(din));
               @(negedge clk);
            end
            in_valid = 1'b0;
         end
         begin
            int rcv = 0, cyc = 0;
            while (rcv < 20 && cyc < 3000) begin
               out_ready = $urandom_range(0, 2) != 0;
               if (ov4 && out_ready) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL rand_extra got %h want none", o4);
                  end else chk($sformatf("rand%0d", rcv), o4, exp_q.pop_front());
                  rcv++;
               end
               @(negedge clk);
               cyc++;
            end
            chk("rand_count", 128'(rcv), 128'd20);
         end
      join
      chk("rand_left", 128'(exp_q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
